// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master engine among N_REQ requesters.
// Optional engine watchdog is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_rw,
    input  logic [7*N_REQ-1:0] req_addr,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic [7:0]         rdata,
    output logic               nack,
    output logic               eng_start,
    output logic               eng_rw,
    output logic [6:0]         eng_addr,
    output logic [7:0]         eng_wdata,
    input  logic               eng_busy,
    input  logic               eng_done,
    input  logic [7:0]         eng_rdata,
    input  logic               eng_nack,
    output logic               eng_abort
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("i2c_txn_arbiter: unsupported N_REQ or TIMEOUT_CYC");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          found;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] cnt;
`else
    assign eng_abort = 1'b0;
`endif

    // Search last+1, last+2, ... with wrap; first set request wins.
    always_comb begin
        pick  = last;
        cand  = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (int'(last) + k >= N_REQ)
                cand = IW'(int'(last) + k - N_REQ);
            else
                cand = IW'(int'(last) + k);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            last      <= IW'(N_REQ - 1);
            grant     <= '0;
            done      <= '0;
            rdata     <= '0;
            nack      <= 1'b0;
            eng_start <= 1'b0;
            eng_rw    <= 1'b0;
            eng_addr  <= '0;
            eng_wdata <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt       <= '0;
            eng_abort <= 1'b0;
`endif
        end else begin
            done      <= '0;
            eng_start <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            eng_abort <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        last      <= pick;
                        grant     <= N_REQ'(1) << pick;
                        eng_rw    <= req_rw[pick];
                        eng_addr  <= req_addr[7*pick +: 7];
                        eng_wdata <= req_wdata[8*pick +: 8];
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (!eng_busy) begin
                        eng_start <= 1'b1;
                        state     <= S_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    // A completion in the timeout cycle takes priority.
                    if (eng_done) begin
                        rdata <= eng_rdata;
                        nack  <= eng_nack;
                        done  <= grant;
                        state <= S_RESP;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        eng_abort <= 1'b1;
                        rdata     <= '0;
                        nack      <= 1'b1;
                        done      <= grant;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                S_RESP: begin
                    grant <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter with a behavioural engine model.
module tb_i2c_txn_arbiter;

    localparam int N  = 4;
    localparam int TO = 100;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   req_rw = '0;
    logic [7*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [7:0]     rdata;
    logic           nack;
    logic           eng_start;
    logic           eng_rw;
    logic [6:0]     eng_addr;
    logic [7:0]     eng_wdata;
    logic           eng_busy;
    logic           eng_done = 1'b0;
    logic [7:0]     eng_rdata = '0;
    logic           eng_nack = 1'b0;
    logic           eng_abort;

    logic eng_active = 1'b0;
    logic busy_force = 1'b0;
    logic auto_drop  = 1'b1;
    logic prev_ed    = 1'b0;

    assign eng_busy = eng_active | busy_force;

    i2c_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(grant), .done(done), .rdata(rdata), .nack(nack),
        .eng_start(eng_start), .eng_rw(eng_rw), .eng_addr(eng_addr),
        .eng_wdata(eng_wdata), .eng_busy(eng_busy), .eng_done(eng_done),
        .eng_rdata(eng_rdata), .eng_nack(eng_nack), .eng_abort(eng_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic         rw;
        logic [6:0]   addr;
        logic [7:0]   wdata;
    } start_t;

    typedef struct {
        logic [N-1:0] done;
        logic [7:0]   rdata;
        logic         nack;
        logic         abort;
    } resp_t;

    typedef struct {
        logic [7:0] rdata;
        logic       nack;
        int         delay;
    } eng_t;

    start_t start_q[$];
    resp_t  resp_q[$];
    eng_t   eng_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_fields(input int i, input logic rw,
                              input logic [6:0] a, input logic [7:0] wd);
        req_rw[i]          = rw;
        req_addr[7*i +: 7] = a;
        req_wdata[8*i +: 8] = wd;
    endtask

    task automatic expect_txn(input logic [N-1:0] g, input logic rw,
                              input logic [6:0] a, input logic [7:0] wd,
                              input logic [7:0] rd, input logic nk,
                              input int dly, input logic with_resp);
        start_t s;
        resp_t  r;
        eng_t   e;
        s.grant = g; s.rw = rw; s.addr = a; s.wdata = wd;
        start_q.push_back(s);
        e.rdata = rd; e.nack = nk; e.delay = dly;
        eng_q.push_back(e);
        if (with_resp) begin
            r.done = g; r.rdata = rd; r.nack = nk; r.abort = 1'b0;
            resp_q.push_back(r);
        end
    endtask

    task automatic wait_drain(input int max, input string name);
        int k;
        k = 0;
        while ((start_q.size() != 0 || resp_q.size() != 0) && k < max) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(k < max), 32'd1);
        @(negedge clk);
    endtask

    // Engine model: accepts a launch, then completes after the queued delay.
    initial begin
        eng_t cur;
        int   ecnt;
        cur.rdata = '0; cur.nack = 1'b0; cur.delay = 0;
        ecnt = 0;
        forever begin
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (!rst) begin
                eng_active = 1'b0;
            end else if (eng_active) begin
                if (ecnt == 0) begin
                    eng_done   = 1'b1;
                    eng_rdata  = cur.rdata;
                    eng_nack   = cur.nack;
                    eng_active = 1'b0;
                end else begin
                    ecnt--;
                end
            end else if (eng_start) begin
                if (eng_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL eng_launch: got 1 expected 0");
                end else begin
                    cur        = eng_q.pop_front();
                    ecnt       = cur.delay;
                    eng_active = 1'b1;
                end
            end
        end
    end

    // Monitor: compare launches and completions against the scoreboard.
    initial begin
        start_t s;
        resp_t  r;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (eng_start) begin
                    if (start_q.size() == 0) begin
                        check("start_unexpected", 32'd1, 32'd0);
                    end else begin
                        s = start_q.pop_front();
                        check("start_grant", 32'(grant), 32'(s.grant));
                        check("start_addr", 32'(eng_addr), 32'(s.addr));
                        check("start_wdata", 32'(eng_wdata), 32'(s.wdata));
                        check("start_rw", 32'(eng_rw), 32'(s.rw));
                    end
                end
                if (done != '0) begin
                    if (resp_q.size() == 0) begin
                        check("done_unexpected", 32'(done), 32'd0);
                    end else begin
                        r = resp_q.pop_front();
                        check("done_vec", 32'(done), 32'(r.done));
                        check("done_rdata", 32'(rdata), 32'(r.rdata));
                        check("done_nack", 32'(nack), 32'(r.nack));
                        check("done_abort", 32'(eng_abort), 32'(r.abort));
                        check("done_after_eng_done", 32'(prev_ed), 32'(!r.abort));
                    end
                end
            end
            prev_ed = eng_done;
        end
    end

    // Requesters drop their request on their done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_drop && rst)
                req = req & ~done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int k;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", 32'({grant, done, nack, eng_start, eng_rw, eng_abort}), 32'd0);
        check("reset_data", 32'({rdata, eng_addr, eng_wdata}), 32'd0);
        rst = 1'b1;

        // Single write from requester 0 with latency checks.
        @(posedge clk);
        #1;
        set_fields(0, 1'b0, 7'h48, 8'hA5);
        expect_txn(4'b0001, 1'b0, 7'h48, 8'hA5, 8'h77, 1'b0, 50, 1'b1);
        req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lat_grant", 32'(grant), 32'b0001);
        check("lat_nostart", 32'(eng_start), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_start", 32'(eng_start), 32'd1);
        wait_drain(200, "write_drain");

        // Read from requester 2.
        @(posedge clk);
        #1;
        set_fields(2, 1'b1, 7'h1D, 8'h00);
        expect_txn(4'b0100, 1'b1, 7'h1D, 8'h00, 8'h3C, 1'b0, 20, 1'b1);
        req[2] = 1'b1;
        wait_drain(200, "read_drain");

        // NACK on requester 1.
        @(posedge clk);
        #1;
        set_fields(1, 1'b0, 7'h50, 8'h11);
        expect_txn(4'b0010, 1'b0, 7'h50, 8'h11, 8'h00, 1'b1, 10, 1'b1);
        req[1] = 1'b1;
        wait_drain(200, "nack_drain");

        // Engine busy holds LAUNCH; nack clears on the next transaction.
        @(posedge clk);
        #1;
        busy_force = 1'b1;
        set_fields(3, 1'b0, 7'h2A, 8'h5A);
        expect_txn(4'b1000, 1'b0, 7'h2A, 8'h5A, 8'h00, 1'b0, 8, 1'b1);
        req[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("busy_grant", 32'(grant), 32'b1000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("busy_nostart", 32'(eng_start), 32'd0);
        end
        @(posedge clk);
        #1;
        busy_force = 1'b0;
        wait_drain(200, "busy_drain");

        // Round robin with all requests held: 0,1,2,3,0.
        auto_drop = 1'b0;
        for (int i = 0; i < N; i++)
            set_fields(i, i[0], 7'(8'h10 + i), 8'(8'hC0 + i));
        for (int n = 0; n < 5; n++) begin
            int g;
            g = n % N;
            expect_txn(N'(1) << g, g[0], 7'(8'h10 + g), 8'(8'hC0 + g),
                       8'(8'h90 + n), 1'b0, 5, 1'b1);
        end
        @(posedge clk);
        #1;
        req = 4'b1111;
        nd = 0;
        k = 0;
        while (nd < 5 && k < 400) begin
            @(negedge clk);
            k++;
            if (done != '0) begin
                nd++;
                if (nd == 4) req = 4'b0001;
                if (nd == 5) req = 4'b0000;
            end
        end
        check("rr_count", 32'(nd), 32'd5);
        auto_drop = 1'b1;
        wait_drain(100, "rr_drain");

        // Reset while waiting on the engine.
        @(posedge clk);
        #1;
        set_fields(0, 1'b0, 7'h48, 8'hA5);
        expect_txn(4'b0001, 1'b0, 7'h48, 8'hA5, 8'h00, 1'b0, 300, 1'b0);
        req[0] = 1'b1;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            seen = eng_start;
        end
        check("rst_launch_seen", 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_ctl", 32'({grant, done, nack, eng_start, eng_rw, eng_abort}), 32'd0);
        check("rst_mid_data", 32'({rdata, eng_addr, eng_wdata}), 32'd0);
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // After reset requester 0 wins first.
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            set_fields(i, 1'b1, 7'(8'h60 + i), 8'(8'hE0 + i));
            expect_txn(N'(1) << i, 1'b1, 7'(8'h60 + i), 8'(8'hE0 + i),
                       8'(8'hA0 + i), 1'b0, 3, 1'b1);
        end
        req = 4'b1111;
        wait_drain(300, "post_rst_drain");

`ifdef I2C_ARB_TIMEOUT_EN
        // Engine never completes: watchdog aborts.
        begin
            resp_t r;
            @(posedge clk);
            #1;
            set_fields(2, 1'b1, 7'h33, 8'h00);
            expect_txn(4'b0100, 1'b1, 7'h33, 8'h00, 8'h00, 1'b0, 5000, 1'b0);
            r.done = 4'b0100; r.rdata = 8'h00; r.nack = 1'b1; r.abort = 1'b1;
            resp_q.push_back(r);
            req[2] = 1'b1;
            seen = 1'b0;
            k = 0;
            while (!seen && k < 20) begin
                @(negedge clk);
                k++;
                seen = eng_start;
            end
            check("to_launch_seen", 32'(seen), 32'd1);
            k = 0;
            while (!eng_abort && k < 300) begin
                @(negedge clk);
                k++;
            end
            check("to_abort_offset", 32'(k), 32'(TO));
            @(negedge clk);
            check("to_abort_pulse", 32'(eng_abort), 32'd0);
            wait_drain(50, "to_drain");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one byte-level I2C master engine (the block driving sda/scl in zybo_z7_top) between N_REQ on-chip requesters.
- Each transaction is START, address+R/W, one data byte, STOP.
- Round-robin arbitration; latches the winner's fields, launches the engine, waits for completion, then returns read data and ACK status to the winner.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 200000, engine watchdog limit in clk cycles (used only with I2C_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req  in  N_REQ  level request per requester; held until that requester's done pulse
- req_rw  in  N_REQ  per requester: 1 = read, 0 = write
- req_addr  in  7*N_REQ  packed 7-bit device addresses; slice i = [7*i+6:7*i]
- req_wdata  in  8*N_REQ  packed write bytes; slice i = [8*i+7:8*i]
- grant  out  N_REQ  one-hot; set for the requester currently owning the engine
- done  out  N_REQ  one-cycle completion pulse to the owner
- rdata  out  8  read byte; valid in the done cycle; shared by all requesters
- nack  out  1  1 = address or data NACK (or timeout); valid in the done cycle
- eng_start  out  1  one-cycle launch pulse to the engine
- eng_rw  out  1  latched R/W
- eng_addr  out  7  latched address
- eng_wdata  out  8  latched write byte
- eng_busy  in  1  engine is mid-transaction
- eng_done  in  1  one-cycle engine completion pulse
- eng_rdata  in  8  engine read byte; valid with eng_done
- eng_nack  in  1  engine NACK flag; valid with eng_done
- eng_abort  out  1  force-STOP request (I2C_ARB_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; grant=0, done=0, rdata=0, nack=0, eng_start=0, eng_rw=0, eng_addr=0, eng_wdata=0, eng_abort=0; last-grant pointer = N_REQ-1, so requester 0 wins first.
- IDLE:
  - If any req is set, pick the first set bit searching last+1, last+2, ... with modulo N_REQ wrap.
  - Register its index, rw, addr and wdata into the eng_* outputs.
  - Set grant one-hot, update the pointer, go to LAUNCH.
- LAUNCH:
  - If eng_busy=0: eng_start=1 for exactly one cycle, go to WAIT.
  - Otherwise hold in LAUNCH with eng_start=0.
- WAIT:
  - On eng_done: capture eng_rdata into rdata and eng_nack into nack, go to RESP.
  - eng_start is never reasserted while waiting.
- RESP: done[idx]=1 for one cycle; next cycle grant=0, state IDLE.
- rdata and nack hold their value until the next capture.
- Latency: req rising in IDLE gives grant at +1 cycle and eng_start at +2 cycles (eng_busy=0).
- Fairness: the mandatory IDLE cycle after RESP re-arbitrates every transaction. A requester holding req continuously gets at most one transaction per round.
- Writes: rdata is still updated from eng_rdata (don't-care value).
- Request withdrawn before grant: not serviced.
- Request withdrawn after grant: the transaction completes and done still pulses.
- Changes on req_* fields after grant are ignored (fields are latched).
- eng_done outside WAIT is ignored.
- Reset mid-transaction returns to IDLE immediately. The engine is expected to share rst.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - On reaching TIMEOUT_CYC-1 without eng_done: eng_abort=1 for one cycle, nack=1, rdata=0, go to RESP.
  - eng_done arriving in the same cycle as the timeout wins: normal capture, no abort.
- Without the macro: no counter; eng_abort is constant 0; WAIT waits indefinitely.

Test Plan:
- Single write: req[0]=1, rw=0, addr=0x48, wdata=0xA5, engine model done after 50 cycles -> grant=0001 at +1, eng_start at +2 with eng_addr=0x48, eng_wdata=0xA5; done[0] one cycle after eng_done; nack=0.
- Read: req[2], rw=1, addr=0x1D, engine returns 0x3C -> done[2] pulses with rdata=0x3C, nack=0.
- Round-robin: req=1111 held continuously -> grant sequence 0001, 0010, 0100, 1000, 0001; no requester is granted twice in a row.
- NACK: engine returns eng_nack=1 for req[1] -> done[1] with nack=1; the next transaction reports nack=0.
- Busy and reset: eng_busy=1 held for 10 cycles in LAUNCH -> no eng_start until busy drops. Assert rst in WAIT -> all outputs 0 on the same edge; after release, req[0] is granted first.
- Timeout (macro on, TIMEOUT_CYC=100, no eng_done) -> eng_abort pulse on the 100th WAIT cycle, then done with nack=1, rdata=0.
